dual_port_sram_8bit: RTL and testbench

// - True dual-port synchronous SRAM: 256 words x 8 bits, two independent read/write ports (A, B).
// - Both ports share one clock; each port writes or reads one word per cycle.
// - General-purpose on-chip buffer/scratchpad. Flop-based array, fully cleared by reset.
//

---
 rtl/sram_pkg.sv | 12 +
 rtl/sram_read_port.sv | 32 +++
 rtl/dual_port_sram_8bit.sv | 60 ++++++
 tb/tb_dual_port_sram_8bit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared sizing and word/address types for the 256 x 8 dual-port SRAM.
// DEPTH is derived from ADDR_WIDTH and is not meant to be overridden.
package sram_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/sram_read_port.sv
// Registered read-data stage for one SRAM port.
// Loads the muxed word on read_en, otherwise holds; cleared by async reset.
module sram_read_port
  import sram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] data_out
);

  word_t data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (read_en) begin
      data_d = rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/dual_port_sram_8bit.sv
// True dual-port 256 x 8 flop-based SRAM on a single clock, fully cleared by reset.
// Reads see pre-edge contents; on a same-address write collision port A wins.
module dual_port_sram_8bit
  import sram_pkg::*;
(
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Port_A_Data_In,
  input  logic [ADDR_WIDTH-1:0] Port_A_Address_In,
  output logic [DATA_WIDTH-1:0] Port_A_Data_Out,
  input  logic                  Port_A_Write_Enable,
  input  logic                  Port_A_Read_Enable,
  input  logic [DATA_WIDTH-1:0] Port_B_Data_In,
  input  logic [ADDR_WIDTH-1:0] Port_B_Address_In,
  output logic [DATA_WIDTH-1:0] Port_B_Data_Out,
  input  logic                  Port_B_Write_Enable,
  input  logic                  Port_B_Read_Enable
);

  word_t mem [DEPTH];
  word_t rd_word_a, rd_word_b;

  // Per-word decode; port A takes precedence when both ports hit the same word.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic hit_a, hit_b;

    assign hit_a = Port_A_Write_Enable && (Port_A_Address_In == addr_t'(i));
    assign hit_b = Port_B_Write_Enable && (Port_B_Address_In == addr_t'(i));

    always_ff @(posedge Clk_In or negedge Reset_In) begin
      if (!Reset_In) begin
        mem[i] <= '0;
      end else if (hit_a) begin
        mem[i] <= Port_A_Data_In;
      end else if (hit_b) begin
        mem[i] <= Port_B_Data_In;
      end
    end
  end

  assign rd_word_a = mem[Port_A_Address_In];
  assign rd_word_b = mem[Port_B_Address_In];

  sram_read_port u_read_a (
    .clk      (Clk_In),
    .rst_n    (Reset_In),
    .read_en  (Port_A_Read_Enable),
    .rd_word  (rd_word_a),
    .data_out (Port_A_Data_Out)
  );

  sram_read_port u_read_b (
    .clk      (Clk_In),
    .rst_n    (Reset_In),
    .read_en  (Port_B_Read_Enable),
    .rd_word  (rd_word_b),
    .data_out (Port_B_Data_Out)
  );

endmodule

// File: tb/tb_dual_port_sram_8bit.sv
// Directed and random-soak bench for dual_port_sram_8bit.
// Directed steps use hand-computed constants; the soak uses a behavioural array model.
module tb_dual_port_sram_8bit;
  import sram_pkg::*;

  logic  clk;
  logic  rst_n;
  word_t a_din, b_din, a_dout, b_dout;
  addr_t a_addr, b_addr;
  logic  a_we, a_re, b_we, b_re;

  int unsigned n_checks;
  int unsigned n_errors;

  word_t mdl [DEPTH];
  word_t exp_a, exp_b;

  dual_port_sram_8bit dut (
    .Clk_In              (clk),
    .Reset_In            (rst_n),
    .Port_A_Data_In      (a_din),
    .Port_A_Address_In   (a_addr),
    .Port_A_Data_Out     (a_dout),
    .Port_A_Write_Enable (a_we),
    .Port_A_Read_Enable  (a_re),
    .Port_B_Data_In      (b_din),
    .Port_B_Address_In   (b_addr),
    .Port_B_Data_Out     (b_dout),
    .Port_B_Write_Enable (b_we),
    .Port_B_Read_Enable  (b_re)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    a_we = 1'b0; a_re = 1'b0; b_we = 1'b0; b_re = 1'b0;
  endtask

  // Advance one edge, keeping the model in step (reads see pre-edge contents).
  task automatic tick();
    if (rst_n) begin
      if (a_re) exp_a = mdl[a_addr];
      if (b_re) exp_b = mdl[b_addr];
      if (b_we) mdl[b_addr] = b_din;
      if (a_we) mdl[a_addr] = a_din;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
    exp_a = '0;
    exp_b = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_model();
    a_din = '0; b_din = '0; a_addr = '0; b_addr = '0;
    idle();
    rst_n = 1'b0;

    // Reset held for two edges
    repeat (2) tick();
    check_eq("reset_a_out", a_dout, 8'h00);
    check_eq("reset_b_out", b_dout, 8'h00);
    rst_n = 1'b1;

    a_re = 1'b1; a_addr = 8'h55;
    tick();
    check_eq("post_reset_read_55", a_dout, 8'h00);

    // Write both ports, then read both back
    idle();
    a_we = 1'b1; a_addr = 8'h81; a_din = 8'h24;
    b_we = 1'b1; b_addr = 8'h63; b_din = 8'h09;
    tick();
    idle();
    a_re = 1'b1; b_re = 1'b1;
    tick();
    check_eq("wr_rd_a_81", a_dout, 8'h24);
    check_eq("wr_rd_b_63", b_dout, 8'h09);

    // Cross-port write then read
    idle();
    a_we = 1'b1; a_addr = 8'h10; a_din = 8'hC3;
    tick();
    idle();
    b_re = 1'b1; b_addr = 8'h10;
    tick();
    check_eq("cross_b_rd_10", b_dout, 8'hC3);

    // Same-cycle cross-port read-before-write
    a_we = 1'b1; a_addr = 8'h10; a_din = 8'h5A;
    tick();
    check_eq("cross_rbw_old", b_dout, 8'hC3);
    idle();
    b_re = 1'b1;
    tick();
    check_eq("cross_rbw_new", b_dout, 8'h5A);

    // Same-port read-before-write
    idle();
    a_we = 1'b1; a_re = 1'b1; a_addr = 8'h10; a_din = 8'h77;
    tick();
    check_eq("same_port_rbw_old", a_dout, 8'h5A);
    a_we = 1'b0;
    tick();
    check_eq("same_port_rbw_new", a_dout, 8'h77);

    // Write collision: A wins
    idle();
    a_we = 1'b1; a_addr = 8'hFF; a_din = 8'hAA;
    b_we = 1'b1; b_addr = 8'hFF; b_din = 8'hBB;
    tick();
    idle();
    b_re = 1'b1; a_re = 1'b1; a_addr = 8'hFF;
    tick();
    check_eq("collision_b_rd", b_dout, 8'hAA);
    check_eq("collision_a_rd", a_dout, 8'hAA);

    // Hold when read enable drops
    idle();
    a_re = 1'b1; a_addr = 8'h81;
    tick();
    check_eq("hold_load", a_dout, 8'h24);
    a_re = 1'b0; a_addr = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("hold_cyc%0d", i), a_dout, 8'h24);
    end

    // Random soak against the model
    for (int it = 0; it < 20; it++) begin
      idle();
      a_we = 1'b1; a_addr = addr_t'($urandom_range(255)); a_din = word_t'($urandom_range(255));
      b_we = 1'b1; b_addr = addr_t'($urandom_range(255)); b_din = word_t'($urandom_range(255));
      if (it % 5 == 0) b_addr = a_addr;
      tick();
      idle();
      a_re = 1'b1; b_re = 1'b1;
      tick();
      check_eq($sformatf("soak_a_%0d", it), a_dout, exp_a);
      check_eq($sformatf("soak_b_%0d", it), b_dout, exp_b);
    end

    // Reset pulse mid-operation with a write pending
    idle();
    a_we = 1'b1; a_addr = 8'h81; a_din = 8'hEE;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_a_out", a_dout, 8'h00);
    check_eq("async_rst_b_out", b_dout, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    clear_model();
    begin
      addr_t probe [4];
      probe[0] = 8'h81; probe[1] = 8'h63; probe[2] = 8'hFF; probe[3] = 8'h10;
      for (int i = 0; i < 4; i++) begin
        a_re = 1'b1; a_addr = probe[i];
        b_re = 1'b1; b_addr = probe[(i + 1) % 4];
        tick();
        check_eq($sformatf("post_rst_a_%0d", i), a_dout, 8'h00);
        check_eq($sformatf("post_rst_b_%0d", i), b_dout, 8'h00);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
